step_ctrl: RTL and testbench
============================

# step_ctrl

Parametrised execution-step controller for the pipeline CPU top level. Debounces the raw step push-button and turns each press into CPU clock-enable pulses in one of four modes: single step, fixed-length burst, free run, or locked. Pulse rate is programmable, a running pulse count is kept for the display, and a CPU halt request stops execution. It drives the CPU clock-enable from the main board clock and replaces the derived button clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 5000, consecutive stable clocks needed before the debounced level changes (>=1)
- BURST_W, 8, width of burst_len and of the internal remaining-pulse counter
- DIV_W, 16, width of run_div
- TICK_W, 8, width of ticks

Ports:
- clk  in  1  board clock; the only clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- step_btn  in  1  raw, asynchronous push-button level
- mode  in  2  0 = single step, 1 = burst, 2 = free run, 3 = locked; sampled only on a press event
- burst_len  in  BURST_W  pulses per burst; sampled on a press event
- run_div  in  DIV_W  pulse period minus one, used in burst and run; sampled on every pulse decision
- halt_req  in  1  level from the CPU; forces stop
- cpu_en  out  1  registered one-cycle clock-enable pulses to the CPU
- busy  out  1  registered; high when the state is not IDLE
- ticks  out  TICK_W  count of cpu_en pulses issued
- btn_level  out  1  debounced button level

## Operation
- Synchroniser: two flops, s1 then s2, with step_btn entering s1.
- Debounce:
  - While s2 equals btn_level, cnt is 0.
  - Otherwise cnt increments each clock.
  - On the clock where cnt == DEBOUNCE_CYCLES-1, btn_level takes s2 and cnt clears.
- Press event: btn_level high and its one-cycle-delayed copy low. Only rising edges count; releases are ignored.
- FSM states are IDLE, STEP, BURST, RUN.
- IDLE, on a press event with halt_req low:
  - mode 0: go to STEP and set cpu_en.
  - mode 1 with burst_len != 0: go to BURST, load rem = burst_len-1, set cpu_en, clear div.
  - mode 1 with burst_len == 0: stay in IDLE.
  - mode 2: go to RUN, set cpu_en, clear div.
  - mode 3: stay in IDLE.
- STEP: go to IDLE next clock; cpu_en 0.
- BURST:
  - div counts 0..run_div.
  - When div == run_div: div clears, and if rem == 0 go to IDLE with no pulse; else cpu_en = 1 and rem decrements.
  - A press event aborts to IDLE.
- RUN: when div == run_div, div clears and cpu_en = 1. A press event goes to IDLE.
- halt_req high:
  - From any state, the next edge goes to IDLE with cpu_en = 0.
  - Halt wins over a pulse due on the same edge.
  - Press events are discarded while halt_req is high.
- Pulse rate in burst and run: one pulse every run_div+1 clocks. run_div = 0 gives cpu_en continuously high.
- ticks increments on every clock where cpu_en is high, wraps modulo 2^TICK_W, and is cleared only by reset.
- mode and burst_len changes take effect only at the next press event. A burst in progress is unaffected by changes to them.

## Timing
- Reset (reset low, asynchronous) gives: cpu_en=0, busy=0, ticks=0, btn_level=0, s1=s2=0, cnt=0, rem=0, div=0, state IDLE.
- Press latency: raw high first sampled at edge 0, then:
  - s2 high at edge 1.
  - btn_level high at edge 1+DEBOUNCE_CYCLES.
  - cpu_en set at edge 2+DEBOUNCE_CYCLES, high for the following clock period.
- A raw pulse or glitch shorter than DEBOUNCE_CYCLES clocks after synchronisation produces no event. A bounce resets cnt.
- Burst of N pulses: first pulse on entry; subsequent pulses run_div+1 clocks apart.
- busy:
  - Rises together with the first cpu_en.
  - After the last pulse, falls run_div+1 clocks later.
  - In STEP, falls the clock after the pulse.
- Button held through reset release: this is a fresh press and fires after the normal latency.
- Reset asserted mid-burst or mid-run: everything returns to reset values immediately. There is no resumption after release.

## Test plan
Benches use DEBOUNCE_CYCLES=4, TICK_W=8.
- Debounce: raw press held 10 clocks in mode 0 -> exactly one cpu_en pulse, at edge 6 after first sample; ticks=1. A 3-clock glitch -> no pulse.
- Burst: mode 1, burst_len=5, run_div=2 -> 5 pulses 3 clocks apart; busy clears 3 clocks after the 5th pulse; ticks=5. burst_len=0 -> no pulse, busy stays 0.
- Run and stop: mode 2, run_div=0 -> cpu_en continuously high. A second press stops it the clock after that press event. ticks equals the high-cycle count.
- Halt: mode 2, run_div=1, halt_req raised on a pulse-due cycle -> no pulse that edge, state IDLE, busy=0. A press while halt_req is high -> ignored.
- Lock, wrap and reset: mode 3 press -> no pulse. Issue 256 pulses -> ticks wraps to 0. reset low mid-burst -> all outputs 0 at once, no pulses after release.

Source files
------------

// File: rtl/step_ctrl.sv
// Execution-step controller: debounces the step button and issues CPU clock-enable
// pulses in single-step, burst, free-run or locked mode, with halt and pulse counting.
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int BURST_W         = 8,
    parameter int DIV_W           = 16,
    parameter int TICK_W          = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_btn,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DIV_W-1:0]   run_div,
    input  logic               halt_req,
    output logic               cpu_en,
    output logic               busy,
    output logic [TICK_W-1:0]  ticks,
    output logic               btn_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STEP  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    logic               s1_reg, s2_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               btn_level_reg, btn_dly_reg;
    logic               press;

    logic [1:0]         state_reg, state_next;
    logic [BURST_W-1:0] rem_reg, rem_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic               cpu_en_reg, cpu_en_next;
    logic               busy_reg, busy_next;
    logic [TICK_W-1:0]  ticks_reg;

    // Synchroniser and debounce: level only moves after a full stable window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg        <= 1'b0;
            s2_reg        <= 1'b0;
            cnt_reg       <= '0;
            btn_level_reg <= 1'b0;
            btn_dly_reg   <= 1'b0;
        end else begin
            s1_reg      <= step_btn;
            s2_reg      <= s1_reg;
            btn_dly_reg <= btn_level_reg;
            if (s2_reg == btn_level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                btn_level_reg <= s2_reg;
                cnt_reg       <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign press = btn_level_reg & ~btn_dly_reg;

    always_comb begin
        state_next  = state_reg;
        rem_next    = rem_reg;
        div_next    = div_reg;
        cpu_en_next = 1'b0;
        if (halt_req) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (press) begin
                        case (mode)
                            2'd0: begin
                                state_next  = ST_STEP;
                                cpu_en_next = 1'b1;
                            end
                            2'd1: begin
                                if (burst_len != '0) begin
                                    state_next  = ST_BURST;
                                    rem_next    = burst_len - BURST_W'(1);
                                    div_next    = '0;
                                    cpu_en_next = 1'b1;
                                end
                            end
                            2'd2: begin
                                state_next  = ST_RUN;
                                div_next    = '0;
                                cpu_en_next = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STEP: state_next = ST_IDLE;
                ST_BURST: begin
                    if (press) begin
                        state_next = ST_IDLE;
                    end else if (div_reg == run_div) begin
                        div_next = '0;
                        if (rem_reg == '0) begin
                            state_next = ST_IDLE;
                        end else begin
                            cpu_en_next = 1'b1;
                            rem_next    = rem_reg - BURST_W'(1);
                        end
                    end else begin
                        div_next = div_reg + DIV_W'(1);
                    end
                end
                ST_RUN: begin
                    if (press) begin
                        state_next = ST_IDLE;
                    end else if (div_reg == run_div) begin
                        div_next    = '0;
                        cpu_en_next = 1'b1;
                    end else begin
                        div_next = div_reg + DIV_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign busy_next = (state_next != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            rem_reg    <= '0;
            div_reg    <= '0;
            cpu_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            ticks_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rem_reg    <= rem_next;
            div_reg    <= div_next;
            cpu_en_reg <= cpu_en_next;
            busy_reg   <= busy_next;
            if (cpu_en_reg) begin
                ticks_reg <= ticks_reg + TICK_W'(1);
            end
        end
    end

    assign cpu_en    = cpu_en_reg;
    assign busy      = busy_reg;
    assign ticks     = ticks_reg;
    assign btn_level = btn_level_reg;

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: stimulus queues expected pulse cycles, a negedge
// monitor pops and checks each cpu_en pulse, and directed checks cover state snapshots.
module tb_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_btn;
    logic [1:0]  mode;
    logic [7:0]  burst_len;
    logic [15:0] run_div;
    logic        halt_req;
    logic        cpu_en;
    logic        busy;
    logic [7:0]  ticks;
    logic        btn_level;

    typedef struct {
        int         cyc;
        logic [7:0] tk;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_ticks = 8'd0;

    step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BURST_W(8),
        .DIV_W(16),
        .TICK_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step_btn(step_btn),
        .mode(mode),
        .burst_len(burst_len),
        .run_div(run_div),
        .halt_req(halt_req),
        .cpu_en(cpu_en),
        .busy(busy),
        .ticks(ticks),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push_pulses(input int first, input int period, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back('{first + i * period, exp_ticks});
            exp_ticks = exp_ticks + 8'd1;
        end
    endtask

    task automatic press(input int hold);
        step_btn = 1'b1;
        tick(hold);
        step_btn = 1'b0;
    endtask

    // Monitor: every cpu_en pulse must match the next expected transaction.
    always @(negedge clk) begin
        if (reset === 1'b1 && cpu_en === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse at cyc %0d: got pulse, expected none (ticks=%0d)", cyc, ticks);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_ticks", int'(ticks), int'(e.tk));
                check("pulse_busy", int'(busy), 1);
                $display("pulse cyc=%0d exp_cyc=%0d ticks=%0d", cyc, e.cyc, ticks);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at cyc %0d: got timeout, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, c0, c1, p, n;
        reset = 1'b0; step_btn = 1'b0; mode = 2'd0; burst_len = 8'd0;
        run_div = 16'd0; halt_req = 1'b0;
        tick(3);
        check("rst_cpu_en", int'(cpu_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ticks", int'(ticks), 0);
        check("rst_btn_level", int'(btn_level), 0);
        reset = 1'b1;
        tick(3);

        // Single step with debounce latency
        mode = 2'd0;
        c = cyc;
        push_pulses(c + 7, 1, 1);
        step_btn = 1'b1;
        wait_cyc(c + 5);
        check("dbnc_level_early", int'(btn_level), 0);
        wait_cyc(c + 6);
        check("dbnc_level_on", int'(btn_level), 1);
        wait_cyc(c + 8);
        check("step_busy_fall", int'(busy), 0);
        wait_cyc(c + 10);
        step_btn = 1'b0;
        wait_cyc(c + 25);
        check("step_ticks", int'(ticks), int'(exp_ticks));
        $display("txn single_step ticks=%0d", ticks);

        // 3-clock glitch: no event
        press(3);
        tick(15);
        check("glitch_ticks", int'(ticks), int'(exp_ticks));
        $display("txn glitch ticks=%0d", ticks);

        // Burst of 5, period 3; inputs changed mid-burst must not matter
        mode = 2'd1; burst_len = 8'd5; run_div = 16'd2;
        c = cyc;
        push_pulses(c + 7, 3, 5);
        press(10);
        burst_len = 8'd1; mode = 2'd0;
        wait_cyc(c + 21);
        check("burst_busy_hold", int'(busy), 1);
        wait_cyc(c + 22);
        check("burst_busy_fall", int'(busy), 0);
        check("burst_ticks", int'(ticks), int'(exp_ticks));
        tick(10);
        $display("txn burst5 ticks=%0d", ticks);

        // Burst length zero
        mode = 2'd1; burst_len = 8'd0;
        press(10);
        check("burst0_busy", int'(busy), 0);
        tick(10);
        check("burst0_ticks", int'(ticks), int'(exp_ticks));
        $display("txn burst0 ticks=%0d", ticks);

        // Free run, run_div=0, stopped by second press
        mode = 2'd2; run_div = 16'd0;
        c0 = cyc; c1 = c0 + 30;
        push_pulses(c0 + 7, 1, 30);
        press(10);
        wait_cyc(c1);
        step_btn = 1'b1;
        wait_cyc(c1 + 7);
        check("run_stop_busy", int'(busy), 0);
        check("run_stop_en", int'(cpu_en), 0);
        wait_cyc(c1 + 10);
        step_btn = 1'b0;
        tick(10);
        check("run_ticks", int'(ticks), int'(exp_ticks));
        $display("txn run30 ticks=%0d", ticks);

        // Halt on a pulse-due edge, then a press during halt
        mode = 2'd2; run_div = 16'd1;
        c0 = cyc; p = c0 + 7;
        push_pulses(p, 2, 3);
        press(10);
        wait_cyc(p + 5);
        halt_req = 1'b1;
        tick(1);
        check("halt_busy", int'(busy), 0);
        check("halt_en", int'(cpu_en), 0);
        press(10);
        tick(10);
        check("halt_press_busy", int'(busy), 0);
        halt_req = 1'b0;
        tick(10);
        check("halt_after_busy", int'(busy), 0);
        check("halt_ticks", int'(ticks), int'(exp_ticks));
        $display("txn halt ticks=%0d", ticks);

        // Locked mode
        mode = 2'd3;
        press(10);
        tick(10);
        check("lock_busy", int'(busy), 0);
        check("lock_ticks", int'(ticks), int'(exp_ticks));
        $display("txn lock ticks=%0d", ticks);

        // Run until ticks wraps back to zero
        mode = 2'd2; run_div = 16'd0;
        n = 256 - int'(exp_ticks);
        c0 = cyc; c1 = c0 + n;
        push_pulses(c0 + 7, 1, n);
        press(10);
        wait_cyc(c1);
        step_btn = 1'b1;
        wait_cyc(c1 + 10);
        step_btn = 1'b0;
        tick(10);
        check("wrap_ticks", int'(ticks), 0);
        $display("txn wrap ticks=%0d", ticks);

        // Reset asserted mid-burst
        mode = 2'd1; burst_len = 8'd5; run_div = 16'd2;
        c = cyc;
        push_pulses(c + 7, 3, 2);
        press(10);
        wait_cyc(c + 11);
        reset = 1'b0;
        #1;
        exp_ticks = 8'd0;
        check("midrst_cpu_en", int'(cpu_en), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ticks", int'(ticks), 0);
        check("midrst_btn_level", int'(btn_level), 0);
        tick(3);
        reset = 1'b1;
        tick(30);
        check("postrst_busy", int'(busy), 0);
        check("postrst_ticks", int'(ticks), int'(exp_ticks));
        $display("txn reset_mid_burst ticks=%0d", ticks);

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
